// File: rtl/map_table_ckpt.sv
// Register map table for a Tomasulo/ROB core with branch checkpoints. It tracks the
// producing tag per architectural register, snoops the CDB, and restores a snapshot in one cycle.
module map_table_ckpt #(
  parameter  int NUM_ARCH_REGS = 32,
  parameter  int TAG_W         = 5,
  parameter  int NUM_CDB       = 2,
  parameter  int NUM_CKPT      = 4,
  localparam int IDX_W         = $clog2(NUM_ARCH_REGS),
  localparam int CK_W          = $clog2(NUM_CKPT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     disp_valid,
  input  logic [IDX_W-1:0]         disp_rs1_idx,
  input  logic [IDX_W-1:0]         disp_rs2_idx,
  input  logic [IDX_W-1:0]         disp_rd_idx,
  input  logic [TAG_W-1:0]         disp_tag,
  input  logic                     disp_ckpt_req,
  output logic                     rs1_busy,
  output logic [TAG_W-1:0]         rs1_tag,
  output logic                     rs1_ready,
  output logic                     rs2_busy,
  output logic [TAG_W-1:0]         rs2_tag,
  output logic                     rs2_ready,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic                     ret_valid,
  input  logic [IDX_W-1:0]         ret_rd_idx,
  input  logic [TAG_W-1:0]         ret_tag,
  output logic                     ckpt_grant,
  output logic [CK_W-1:0]          ckpt_id,
  output logic                     ckpt_full,
  input  logic                     ckpt_release,
  input  logic [CK_W-1:0]          ckpt_release_id,
  input  logic                     restore_valid,
  input  logic [CK_W-1:0]          restore_id,
  input  logic [NUM_CKPT-1:0]      restore_free_mask
);

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t ARF = '0;

  entry_t              live_q   [NUM_ARCH_REGS];
  entry_t              live_upd [NUM_ARCH_REGS];
  entry_t              live_nxt [NUM_ARCH_REGS];
  entry_t              ck_q     [NUM_CKPT][NUM_ARCH_REGS];
  entry_t              ck_upd   [NUM_CKPT][NUM_ARCH_REGS];
  entry_t              ck_nxt   [NUM_CKPT][NUM_ARCH_REGS];
  logic [NUM_CKPT-1:0] used_q;
  logic [NUM_CKPT-1:0] used_nxt;
  entry_t              rs1_e;
  entry_t              rs2_e;

  function automatic logic cdb_hit(input logic [TAG_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  // Retire beats CDB for the same entry; a retire whose tag no longer matches is stale.
  function automatic entry_t snoop(input entry_t e, input logic [IDX_W-1:0] idx);
    entry_t r;
    r = e;
    if (ret_valid && ret_rd_idx == idx && e.busy && e.tag == ret_tag)
      r = ARF;
    else if (e.busy && !e.ready && cdb_hit(e.tag))
      r.ready = 1'b1;
    return r;
  endfunction

  // Lookup reads the pre-update table, with a same-cycle CDB bypass for pending sources.
  always_comb begin
    rs1_e     = live_q[disp_rs1_idx];
    rs2_e     = live_q[disp_rs2_idx];
    rs1_busy  = rs1_e.busy;
    rs1_tag   = rs1_e.busy ? rs1_e.tag : '0;
    rs1_ready = rs1_e.busy && (rs1_e.ready || cdb_hit(rs1_e.tag));
    rs2_busy  = rs2_e.busy;
    rs2_tag   = rs2_e.busy ? rs2_e.tag : '0;
    rs2_ready = rs2_e.busy && (rs2_e.ready || cdb_hit(rs2_e.tag));
  end

  // Lowest free slot; reads 0 when every slot is taken.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    ckpt_id = '0;
    for (int k = NUM_CKPT - 1; k >= 0; k--)
      if (!used_q[k]) ckpt_id = CK_W'(k);
  end

  assign ckpt_full  = &used_q;
  assign ckpt_grant = disp_valid && disp_ckpt_req && !ckpt_full && !restore_valid;

  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++)
      live_upd[i] = snoop(live_q[i], IDX_W'(i));
    for (int k = 0; k < NUM_CKPT; k++)
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        ck_upd[k][i] = snoop(ck_q[k][i], IDX_W'(i));
  end

  // The snapshot takes the CDB/retire-updated table but not the branch's own dispatch write.
  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      live_nxt[i] = live_upd[i];
      if (restore_valid)
        live_nxt[i] = ck_upd[restore_id][i];
      else if (disp_valid && disp_rd_idx == IDX_W'(i))
        live_nxt[i] = '{busy: 1'b1, ready: 1'b0, tag: disp_tag};
    end
    live_nxt[0] = ARF;
    for (int k = 0; k < NUM_CKPT; k++)
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        ck_nxt[k][i] = (ckpt_grant && ckpt_id == CK_W'(k)) ? live_upd[i] : ck_upd[k][i];
  end

  always_comb begin
    used_nxt = used_q;
    if (restore_valid) begin
      used_nxt = used_q & ~restore_free_mask;
    end else begin
      if (ckpt_release) used_nxt[ckpt_release_id] = 1'b0;
      if (ckpt_grant)   used_nxt[ckpt_id]         = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the checkpoint copies are reset too, so a restore of a never-written slot yields ARF.
      for (int i = 0; i < NUM_ARCH_REGS; i++) live_q[i] <= ARF;
      for (int k = 0; k < NUM_CKPT; k++)
        for (int i = 0; i < NUM_ARCH_REGS; i++) ck_q[k][i] <= ARF;
      used_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < NUM_ARCH_REGS; i++) live_q[i] <= live_nxt[i];
      for (int k = 0; k < NUM_CKPT; k++)
        for (int i = 0; i < NUM_ARCH_REGS; i++) ck_q[k][i] <= ck_nxt[k][i];
      used_q <= used_nxt;
    end
  end

endmodule

// File: tb/tb_map_table_ckpt.sv
// Directed bench for map_table_ckpt: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops and compares them against the live outputs.
module tb_map_table_ckpt;

  localparam int TAG_W = 5;
  localparam int IDX_W = 5;
  localparam int CK_W  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             disp_valid, disp_ckpt_req;
  logic [IDX_W-1:0] disp_rs1_idx, disp_rs2_idx, disp_rd_idx;
  logic [TAG_W-1:0] disp_tag;
  logic             rs1_busy, rs1_ready, rs2_busy, rs2_ready;
  logic [TAG_W-1:0] rs1_tag, rs2_tag;
  logic [1:0]       cdb_valid;
  logic [9:0]       cdb_tag;
  logic             ret_valid;
  logic [IDX_W-1:0] ret_rd_idx;
  logic [TAG_W-1:0] ret_tag;
  logic             ckpt_grant, ckpt_full, ckpt_release, restore_valid;
  logic [CK_W-1:0]  ckpt_id, ckpt_release_id, restore_id;
  logic [3:0]       restore_free_mask;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } rec_t;

  rec_t q[$];
  logic probe = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  map_table_ckpt dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
    .disp_rd_idx(disp_rd_idx), .disp_tag(disp_tag), .disp_ckpt_req(disp_ckpt_req),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_ready(rs1_ready),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_ready(rs2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .ret_valid(ret_valid), .ret_rd_idx(ret_rd_idx), .ret_tag(ret_tag),
    .ckpt_grant(ckpt_grant), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .ckpt_release(ckpt_release), .ckpt_release_id(ckpt_release_id),
    .restore_valid(restore_valid), .restore_id(restore_id),
    .restore_free_mask(restore_free_mask)
  );

  always #5 clock = ~clock;

  // Packed layout: {rs1 busy,tag,ready, rs2 busy,tag,ready, grant, id, full}
  function automatic logic [17:0] mk(input logic b1, input logic [4:0] t1, input logic r1,
                                     input logic b2, input logic [4:0] t2, input logic r2,
                                     input logic g, input logic [1:0] id, input logic f);
    return {b1, t1, r1, b2, t2, r2, g, id, f};
  endfunction

  always @(negedge clock) begin
    if (probe) begin
      logic [17:0] act;
      act = {rs1_busy, rs1_tag, rs1_ready, rs2_busy, rs2_tag, rs2_ready,
             ckpt_grant, ckpt_id, ckpt_full};
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: output sampled but no expectation queued, got %h", act);
      end else begin
        rec_t r;
        r = q.pop_front();
        if (act !== r.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", r.name, act, r.exp);
        end
      end
    end
  end

  task automatic idle();
    disp_valid = 0; disp_ckpt_req = 0; disp_rs1_idx = 0; disp_rs2_idx = 0;
    disp_rd_idx = 0; disp_tag = 0; cdb_valid = 0; cdb_tag = 0;
    ret_valid = 0; ret_rd_idx = 0; ret_tag = 0; ckpt_release = 0; ckpt_release_id = 0;
    restore_valid = 0; restore_id = 0; restore_free_mask = 0;
  endtask

  task automatic expect_out(input string name, input logic [17:0] e);
    rec_t r;
    r.name = name;
    r.exp  = e;
    q.push_back(r);
    probe = 1'b1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
    probe = 1'b0;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [4:0] tag);
    disp_valid = 1; disp_rd_idx = rd; disp_tag = tag;
  endtask

  task automatic rd_src(input logic [4:0] s1, input logic [4:0] s2);
    disp_rs1_idx = s1; disp_rs2_idx = s2;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    rd_src(5, 0);                                   expect_out("reset_state", mk(0,0,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); disp(5, 3);                       expect_out("disp_sees_old", mk(0,0,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0);                                   expect_out("pending_5", mk(1,3,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0};
                                                    expect_out("cdb_bypass", mk(1,3,1, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); ret_valid = 1; ret_rd_idx = 5; ret_tag = 3;
                                                    expect_out("done_5", mk(1,3,1, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); disp(5, 7);                       expect_out("retired_5", mk(0,0,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); ret_valid = 1; ret_rd_idx = 5; ret_tag = 3;
                                                    expect_out("remap_5", mk(1,7,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 0); disp(6, 4);                       expect_out("stale_retire", mk(1,7,0, 0,0,0, 0,0,0)); tick();
    rd_src(5, 6); disp(6, 10); ret_valid = 1; ret_rd_idx = 6; ret_tag = 4;
                                                    expect_out("disp_ret_same", mk(1,7,0, 1,4,0, 0,0,0)); tick();
    rd_src(5, 6);                                   expect_out("disp_wins", mk(1,7,0, 1,10,0, 0,0,0)); tick();

    // Branch checkpoint, then mispredict back to it.
    rd_src(5, 6); disp(0, 0); disp_ckpt_req = 1;    expect_out("grant_0", mk(1,7,0, 1,10,0, 1,0,0)); tick();
    rd_src(8, 6); disp(8, 9);                       expect_out("after_grant", mk(0,0,0, 1,10,0, 0,1,0)); tick();
    rd_src(8, 0); cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9};
                                                    expect_out("bypass_8", mk(1,9,1, 0,0,0, 0,1,0)); tick();
    rd_src(8, 0); restore_valid = 1; restore_id = 0; restore_free_mask = 4'b0001;
                                                    expect_out("restore_old_out", mk(1,9,1, 0,0,0, 0,1,0)); tick();
    rd_src(8, 5);                                   expect_out("restored", mk(0,0,0, 1,7,0, 0,0,0)); tick();

    // Restore with a CDB hit on a snapshotted pending entry.
    rd_src(4, 0); disp(4, 2);                       expect_out("disp_4", mk(0,0,0, 0,0,0, 0,0,0)); tick();
    rd_src(4, 0); disp(0, 0); disp_ckpt_req = 1;    expect_out("grant_snap4", mk(1,2,0, 0,0,0, 1,0,0)); tick();
    rd_src(4, 0); disp(4, 12);                      expect_out("pre_overwrite", mk(1,2,0, 0,0,0, 0,1,0)); tick();
    rd_src(4, 0); restore_valid = 1; restore_id = 0; restore_free_mask = 4'b0001;
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd2};      expect_out("restore_cdb", mk(1,12,0, 0,0,0, 0,1,0)); tick();
    rd_src(4, 0);                                   expect_out("restored_done", mk(1,2,1, 0,0,0, 0,0,0)); tick();

    // Fill every slot, overflow, release slot 2 and reallocate it.
    for (int k = 0; k < 4; k++) begin
      disp(0, 0); disp_ckpt_req = 1;
      expect_out($sformatf("fill_%0d", k), mk(0,0,0, 0,0,0, 1,2'(k),0));
      tick();
    end
    disp(0, 0); disp_ckpt_req = 1; ckpt_release = 1; ckpt_release_id = 2;
                                                    expect_out("full_no_grant", mk(0,0,0, 0,0,0, 0,0,1)); tick();
    disp(0, 0); disp_ckpt_req = 1;                  expect_out("regrant_2", mk(0,0,0, 0,0,0, 1,2,0)); tick();
                                                    expect_out("full_again", mk(0,0,0, 0,0,0, 0,0,1)); tick();

    // Reset asserted together with a restore: reset wins.
    reset = 1'b1; restore_valid = 1; restore_id = 1; restore_free_mask = 4'b0010;
    tick();
    reset = 1'b0;
    rd_src(4, 5);                                   expect_out("reset_mid_restore", mk(0,0,0, 0,0,0, 0,0,0)); tick();

    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clock);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/map_table_ckpt.md
Name: map_table_ckpt

Overview:
- Parametrised Tomasulo/ROB register map table: tracks which in-flight tag will produce each architectural register, and whether that result is already on the CDB.
- Sits between decode/dispatch and the RS/ROB. Supplies source tags and ready bits at dispatch, snoops multiple CDB ports, and clears mappings at retire.
- Adds branch checkpoints: the table is snapshotted on branch dispatch and restored in one cycle on mispredict.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; index 0 is hard-wired zero and never mapped.
- TAG_W, 5, width of ROB/RS tag.
- NUM_CDB, 2, CDB broadcast ports snooped per cycle.
- NUM_CKPT, 4, checkpoint slots.
- Derived: IDX_W = $clog2(NUM_ARCH_REGS); CK_W = $clog2(NUM_CKPT).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- disp_valid  in  1  dispatch one instruction this cycle.
- disp_rs1_idx  in  IDX_W  source 1 register.
- disp_rs2_idx  in  IDX_W  source 2 register.
- disp_rd_idx  in  IDX_W  destination register (0 = no write).
- disp_tag  in  TAG_W  tag allocated to the destination.
- disp_ckpt_req  in  1  instruction is a branch; snapshot the table.
- rs1_busy / rs2_busy  out  1 each  source is mapped to an in-flight tag.
- rs1_tag / rs2_tag  out  TAG_W each  mapped tag (0 when not busy).
- rs1_ready / rs2_ready  out  1 each  mapped tag already broadcast, value readable from ROB.
- cdb_valid  in  NUM_CDB  per-port broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  per-port broadcast tag.
- ret_valid  in  1  ROB retiring an instruction.
- ret_rd_idx  in  IDX_W  retiring destination.
- ret_tag  in  TAG_W  retiring tag.
- ckpt_grant  out  1  snapshot taken this cycle (combinational).
- ckpt_id  out  CK_W  slot granted (lowest free index).
- ckpt_full  out  1  no free slot.
- ckpt_release  in  1  branch resolved correct; free ckpt_release_id.
- ckpt_release_id  in  CK_W  slot to free.
- restore_valid  in  1  mispredict; restore slot restore_id.
- restore_id  in  CK_W  slot to restore.
- restore_free_mask  in  NUM_CKPT  slots freed on restore; must include restore_id.

Behaviour:
- Entry state per register: {busy, ready, tag}.
  - ARF = busy 0.
  - PENDING = busy 1, ready 0.
  - DONE = busy 1, ready 1.
  - Register 0 is always ARF.
- Reset:
  - All entries and all checkpoint copies go to ARF; all slots free.
  - Outputs: busy/ready/tag 0, ckpt_grant 0, ckpt_full 0.
- Lookup (combinational, reads the pre-update table):
  - A source equal to disp_rd_idx sees the old mapping.
  - CDB bypass: a source that is PENDING and whose tag matches any valid cdb_tag this cycle reports ready 1.
- Dispatch (disp_valid, rd != 0): entry becomes PENDING with disp_tag at the next edge.
- CDB: each PENDING entry whose tag matches any valid port becomes DONE. Applied to the live table and to every valid checkpoint copy.
- Retire: if entry[ret_rd_idx].tag == ret_tag and the entry is busy, it becomes ARF. A tag mismatch means the register was remapped; no change. Applied to the live table and all checkpoint copies.
- Per-entry priority within a cycle: dispatch > retire > CDB.
- Checkpoint:
  - On disp_valid && disp_ckpt_req && !ckpt_full, the slot ckpt_id captures the table after this cycle's CDB/retire updates and before this cycle's dispatch write. The branch's own rd does not apply to the snapshot.
  - The slot is marked used and ckpt_grant = 1.
  - If ckpt_full, ckpt_grant = 0 and no snapshot is taken. The dispatcher must stall; the table still updates if disp_valid.
- Release: ckpt_release frees the slot at the next edge. Releasing a free slot has no effect.
- Restore:
  - restore_valid overrides dispatch, checkpoint, and release that cycle.
  - The live table loads the checkpoint copy with this cycle's CDB and retire updates applied.
  - All slots in restore_free_mask become free.
  - Outputs are still driven from the old table that cycle; the dispatcher must not dispatch during restore.
- Free-slot accounting: a slot freed in cycle N is allocatable in cycle N+1. ckpt_full is registered-state based.
- Reset mid-restore: reset wins.

Test Plan:
- Reset, then dispatch rd=5, tag=3; next cycle read rs1=5 -> busy 1, tag 3, ready 0; read rs2=0 -> busy 0, tag 0.
- CDB port1 tag=3 in the same cycle as a read of rs1=5 -> ready 1 via bypass; next cycle entry 5 is DONE. Retire rd=5 tag=3 -> entry 5 is ARF.
- Dispatch rd=5 tag=7, then retire rd=5 tag=3 -> entry 5 stays PENDING tag 7. Dispatch and retire of rd=6 in the same cycle -> new mapping kept.
- Branch dispatch with ckpt_req (rd=0) -> grant 1, id 0. Dispatch rd=8 tag=9. CDB tag 9. restore_valid id 0, mask 0001 -> entry 8 is ARF, slot 0 free.
- Snapshot holding reg 4 PENDING tag 2; CDB tag 2 in the same cycle as restore -> restored entry 4 is DONE tag 2.
- Fill NUM_CKPT=4 slots -> ckpt_full 1, fifth request gets grant 0. Release id 2 -> next cycle ckpt_full 0 and the next grant is id 2.
